// File: rtl/seq_divider_param.sv
// seq_divider_param
// Multi-cycle restoring divider producing one quotient bit per clock. It
// supports signed (two's-complement) and unsigned operands, chosen at runtime.
// It flags divide-by-zero and signed MIN / -1 overflow. The packed result
// {remainder, quotient} feeds the HI/LO register pair.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request, accepted only while idle (busy = 0)
//   is_signed    1 = signed divide, 0 = unsigned; sampled with start
//   dividend     numerator; sampled with start
//   divisor      denominator; sampled with start
//   busy         operation in progress
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     registered quotient
//   remainder    registered remainder
//   result       {remainder, quotient}
//   div_by_zero  last operation had divisor = 0
//   overflow     last operation was signed MIN / -1
module seq_divider_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output logic               overflow
);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc_q;     // dividend in, quotient bits shift in from the right
    logic [WIDTH-1:0]   acc_r;     // partial remainder
    logic [WIDTH-1:0]   dvs;       // divisor (magnitude after PREP)
    logic [CNT_W-1:0]   cnt;
    logic               sgn_mode;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_pend;
    logic               ovf_pend;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    // Magnitude of a two's-complement value. MIN maps to itself, and that
    // value is correct when it is read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    // Conditional two's-complement negation used to restore result signs.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    // Shift the next dividend bit into the partial remainder. Then subtract at
    // WIDTH+1 bits so that bit WIDTH acts as the borrow (negative) flag.
    assign shifted = {acc_r, acc_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? FIX : PREP;
            PREP: state_nxt = ITER;
            ITER: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            acc_r       <= '0;
            dvs         <= '0;
            cnt         <= '0;
            sgn_mode    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                // Latch the request. The raw dividend stays in acc_q so that
                // the divide-by-zero path can return it unchanged.
                IDLE: begin
                    if (start) begin
                        acc_q    <= dividend;
                        dvs      <= divisor;
                        sgn_mode <= is_signed;
                        dbz_pend <= (divisor == '0);
                        ovf_pend <= 1'b0;
                        neg_q    <= 1'b0;
                        neg_r    <= 1'b0;
                    end
                end
                // Reduce to magnitudes and remember the signs for FIX.
                PREP: begin
                    acc_r <= '0;
                    cnt   <= CNT_INIT;
                    if (sgn_mode) begin
                        acc_q    <= abs_val(acc_q);
                        dvs      <= abs_val(dvs);
                        neg_q    <= acc_q[WIDTH-1] ^ dvs[WIDTH-1];
                        neg_r    <= acc_q[WIDTH-1];
                        ovf_pend <= (acc_q == MIN_VAL) && (dvs == '1);
                    end
                end
                // One restoring step per clock.
                ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!trial[WIDTH]) begin
                        acc_r <= trial[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_r <= shifted[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b0};
                    end
                end
                // Publish results and flags.
                FIX: begin
                    if (dbz_pend) begin
                        quotient  <= '1;
                        remainder <= acc_q;
                    end else begin
                        quotient  <= cond_neg(acc_q, neg_q);
                        remainder <= cond_neg(acc_r, neg_r);
                    end
                    div_by_zero <= dbz_pend;
                    overflow    <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign result = {remainder, quotient};

endmodule

// File: tb/tb_seq_divider_param.sv
// Testbench for seq_divider_param: a 32-bit and an 8-bit instance, checked
// against an arithmetic reference model.
module tb_seq_divider_param;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        start32, sgn32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dbz32, ovf32;
    logic [31:0] q32, r32;
    logic [63:0] res32;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8, ovf8;
    logic [7:0]  q8, r8;
    logic [15:0] res8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .is_signed(sgn32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .result(res32),
        .div_by_zero(dbz32), .overflow(ovf32));

    seq_divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .result(res8),
        .div_by_zero(dbz8), .overflow(ovf8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero, with
    // the divide-by-zero and MIN/-1 rules applied on top.
    task automatic model(input int w, input bit sg, input logic [63:0] a_in, input logic [63:0] b_in,
                         output logic [63:0] q, output logic [63:0] r,
                         output bit dbz, output bit ovf);
        logic [63:0] mask, a, b;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q = mask; r = a; dbz = 1'b1;
        end else if (!sg) begin
            q = a / b; r = a % b;
        end else begin
            sa = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
            sb = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
            if (sa == -(longint'(1) <<< (w-1)) && sb == -1) begin
                q = 64'd1 << (w-1); r = 64'd0; ovf = 1'b1;
            end else begin
                q = 64'(sa / sb) & mask;
                r = 64'(sa % sb) & mask;
            end
        end
    endtask

    task automatic drive(input bit w8, input bit st, input bit sg, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = st; sgn8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = st; sgn32 = sg; a32 = a; b32 = b;
        end
    endtask

    function automatic logic [63:0] get_busy(input bit w8); return w8 ? 64'(busy8) : 64'(busy32); endfunction
    function automatic logic [63:0] get_done(input bit w8); return w8 ? 64'(done8) : 64'(done32); endfunction
    function automatic logic [63:0] get_q(input bit w8);    return w8 ? 64'(q8)    : 64'(q32);    endfunction
    function automatic logic [63:0] get_r(input bit w8);    return w8 ? 64'(r8)    : 64'(r32);    endfunction
    function automatic logic [63:0] get_res(input bit w8);  return w8 ? 64'(res8)  : res32;       endfunction
    function automatic logic [63:0] get_dbz(input bit w8);  return w8 ? 64'(dbz8)  : 64'(dbz32);  endfunction
    function automatic logic [63:0] get_ovf(input bit w8);  return w8 ? 64'(ovf8)  : 64'(ovf32);  endfunction

    // One operation. If poke > 0, a 9/9 start is pulsed while busy at that
    // cycle and must be ignored.
    task automatic run_op(input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b, input int poke);
        int          w, lat;
        logic [63:0] eq, er, eres;
        bit          edbz, eovf;
        w = w8 ? 8 : 32;
        model(w, sg, 64'(a), 64'(b), eq, er, edbz, eovf);
        eres = w8 ? {48'd0, er[7:0], eq[7:0]} : {er[31:0], eq[31:0]};
        @(negedge clk);
        drive(w8, 1'b1, sg, a, b);
        @(posedge clk); #1;
        check("busy_rise", get_busy(w8), 64'd1);
        drive(w8, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        lat = 0;
        while (get_done(w8) == 64'd0 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke) drive(w8, 1'b1, 1'b0, 32'd9, 32'd9);
            else if (poke > 0 && lat == poke + 1) drive(w8, 1'b0, 1'b0, $urandom, $urandom);
        end
        check("latency", 64'(lat), edbz ? 64'd1 : 64'(w + 2));
        check("quotient", get_q(w8), eq);
        check("remainder", get_r(w8), er);
        check("result", get_res(w8), eres);
        check("div_by_zero", get_dbz(w8), 64'(edbz));
        check("overflow", get_ovf(w8), 64'(eovf));
        check("busy_fall", get_busy(w8), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        bit          rw8, rsg;
        logic [31:0] ra, rb;
        int          sel;

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_q32", 64'(q32), 64'd0);
        check("rst_r32", 64'(r32), 64'd0);
        check("rst_flags32", 64'({dbz32, ovf32}), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_out8", 64'({q8, r8, dbz8, ovf8, done8}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 32-bit directed
        run_op(1'b0, 1'b0, 32'd100, 32'd3, -1);
        check("res_100_3_const", res32, 64'h00000001_00000021);
        run_op(1'b0, 1'b1, -32'sd7, 32'd2, -1);
        check("neg7_div2_q", 64'(q32), 64'h0000_0000_FFFF_FFFD);
        run_op(1'b0, 1'b1, 32'd7, -32'sd2, -1);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("min_div_m1_q", 64'(q32), 64'h0000_0000_8000_0000);
        run_op(1'b0, 1'b0, 32'd55, 32'd0, -1);
        run_op(1'b0, 1'b0, 32'd55, 32'd10, -1);

        // start pulsed while busy is ignored
        run_op(1'b0, 1'b0, 32'd100, 32'd3, 10);
        // back-to-back: a new start issued in the done cycle
        check("done_for_b2b", 64'(done32), 64'd1);
        run_op(1'b0, 1'b0, 32'd55, 32'd10, -1);

        // reset in the middle of an operation
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_done", 64'(done32), 64'd0);
        check("abort_q", 64'(q32), 64'd0);
        check("abort_r", 64'(r32), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) saw_done = 1'b1;
        end
        check("no_done_after_abort", 64'(saw_done), 64'd0);
        run_op(1'b0, 1'b0, 32'd100, 32'd3, -1);

        // 8-bit directed
        run_op(1'b1, 1'b0, 32'd200, 32'd7, -1);
        check("u200_7_res", 64'(res8), 64'h041C);
        run_op(1'b1, 1'b1, 32'h80, 32'd3, -1);
        check("m128_3_res", 64'(res8), 64'hFED6);
        run_op(1'b1, 1'b1, 32'h80, 32'hFF, -1);
        check("m128_m1_ovf", 64'({q8, ovf8}), 64'h101);
        run_op(1'b1, 1'b0, 32'hFF, 32'hFF, -1);

        // randomized
        for (int i = 0; i < 24; i++) begin
            rw8 = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) begin
                rb = 32'hFFFF_FFFF;
                ra = rw8 ? 32'h80 : 32'h8000_0000;
            end else if (sel < 4) rb = 32'($urandom_range(1, 20));
            else               rb = $urandom;
            if (rw8 && rb[7:0] == 8'd0 && sel != 0) rb = 32'd5;
            run_op(rw8, rsg, ra, rb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
